ps2_device: RTL and testbench

PS2_DEVICE -- requirements
Module: ps2_device

---
 rtl/ps2_device.sv | 226 ++++++++++++++++++++++
 tb/tb_ps2_device.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device.sv
// PS/2 device-side link: sends bytes to the host, receives host-to-device
// frames after a request-to-send, and generates the PS/2 clock in both directions.
module ps2_device #(
  parameter int clkf = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  output logic       ps2_clk_oe,
  input  logic       ps2_dat_in,
  output logic       ps2_dat_oe,
  output logic [3:0] state_dbg
);

  localparam int HALF      = clkf / 25000;
  localparam int IDLE_WAIT = clkf / 20000;
  localparam int TW        = $clog2(IDLE_WAIT + 1);

  localparam logic [TW-1:0] HALF_END = TW'(HALF - 1);
  localparam logic [TW-1:0] HALF_MID = TW'(HALF / 2);
  localparam logic [TW-1:0] IDLE_END = TW'(IDLE_WAIT - 1);

  typedef enum logic [3:0] {
    IDLE,
    TX_LOW,
    TX_HIGH,
    RX_START,
    RX_LOW,
    RX_HIGH,
    ACK_LOW,
    ACK_HIGH,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic          clk_meta, clk_s;
  logic          dat_meta, dat_s;
  logic [TW-1:0] timer;
  logic [3:0]    bit_cnt;
  logic [9:0]    tx_shift;
  logic [9:0]    rx_shift;
  logic [7:0]    tx_hold;
  logic          tx_full;
  logic          rts_armed;
  logic          phase_end;

  // Handshake: tx_data is taken on any rising clk edge where tx_valid and
  // tx_ready are both high; tx_ready stays low until that byte's frame has
  // been fully clocked out, and tx_valid while tx_ready is low is ignored.
  assign tx_ready  = ~tx_full;
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign phase_end = (timer == HALF_END);

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta <= 1'b1;
      clk_s    <= 1'b1;
      dat_meta <= 1'b1;
      dat_s    <= 1'b1;
    end else begin
      clk_meta <= ps2_clk_in;
      clk_s    <= clk_meta;
      dat_meta <= ps2_dat_in;
      dat_s    <= dat_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      tx_hold    <= '0;
      tx_full    <= 1'b0;
      rts_armed  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_error   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;

      if (tx_valid && !tx_full) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          timer   <= '0;
          bit_cnt <= '0;
          // Request-to-send: clock pulled low by the host, then released
          // while data is held low. A release with data high was an inhibit.
          if (!clk_s) begin
            rts_armed <= 1'b1;
          end else if (rts_armed) begin
            rts_armed <= 1'b0;
            if (!dat_s) state <= RX_START;
          end else if (tx_full) begin
            tx_shift   <= {1'b1, ~^tx_hold, tx_hold};
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b1;
            state      <= TX_LOW;
          end
        end

        TX_LOW: begin
          timer <= phase_end ? '0 : timer + 1'b1;
          if (phase_end) begin
            ps2_clk_oe <= 1'b0;
            state      <= TX_HIGH;
          end
        end

        TX_HIGH: begin
          timer <= phase_end ? '0 : timer + 1'b1;
          if (phase_end) begin
            if (!clk_s) begin
              // Host inhibit: drop the frame but keep the byte for a retry.
              ps2_dat_oe <= 1'b0;
              state      <= WAIT_IDLE;
            end else if (bit_cnt == 4'd10) begin
              tx_full    <= 1'b0;
              ps2_dat_oe <= 1'b0;
              state      <= WAIT_IDLE;
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              tx_shift   <= {1'b1, tx_shift[9:1]};
              ps2_dat_oe <= ~tx_shift[0];
              ps2_clk_oe <= 1'b1;
              state      <= TX_LOW;
            end
          end
        end

        RX_START: begin
          timer <= phase_end ? '0 : timer + 1'b1;
          if (phase_end) begin
            bit_cnt    <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= RX_LOW;
          end
        end

        RX_LOW: begin
          timer <= phase_end ? '0 : timer + 1'b1;
          if (phase_end) begin
            ps2_clk_oe <= 1'b0;
            state      <= RX_HIGH;
          end
        end

        RX_HIGH: begin
          timer <= phase_end ? '0 : timer + 1'b1;
          if (timer == HALF_MID) rx_shift <= {dat_s, rx_shift[9:1]};
          if (phase_end) begin
            ps2_clk_oe <= 1'b1;
            if (bit_cnt == 4'd9) begin
              ps2_dat_oe <= 1'b1;
              state      <= ACK_LOW;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              state   <= RX_LOW;
            end
          end
        end

        ACK_LOW: begin
          timer <= phase_end ? '0 : timer + 1'b1;
          if (phase_end) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            state      <= ACK_HIGH;
          end
        end

        ACK_HIGH: begin
          timer <= phase_end ? '0 : timer + 1'b1;
          if (phase_end) begin
            // rx_shift holds {stop, parity, data[7:0]}.
            if (rx_shift[9] && (^rx_shift[8:0])) begin
              rx_data  <= rx_shift[7:0];
              rx_valid <= 1'b1;
            end else begin
              rx_error <= 1'b1;
            end
            state <= WAIT_IDLE;
          end
        end

        WAIT_IDLE: begin
          rts_armed <= 1'b0;
          if (!clk_s || !dat_s) begin
            timer <= '0;
          end else if (timer == IDLE_END) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          timer      <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device.sv
// Directed plus randomized bench for ps2_device: a host model on open-drain
// lines, an 11-bit frame model for transmit and a parity/stop model for receive.
module tb_ps2_device;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       busy;
  logic       ps2_clk_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_in;
  logic       ps2_dat_oe;
  logic [3:0] state_dbg;

  logic host_clk;
  logic host_dat;

  // Open-drain bus: either side may pull low, otherwise pulled up.
  assign ps2_clk_in = host_clk & ~ps2_clk_oe;
  assign ps2_dat_in = host_dat & ~ps2_dat_oe;

  int checks   = 0;
  int failures = 0;
  int nvalid   = 0;
  int nerr     = 0;
  logic [7:0] exp_rx = 8'h00;

  ps2_device #(.clkf(1000000)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_error   (rx_error),
    .busy       (busy),
    .ps2_clk_in (ps2_clk_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_in (ps2_dat_in),
    .ps2_dat_oe (ps2_dat_oe),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) nvalid++;
    if (rx_error === 1'b1) nerr++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ones(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return n;
  endfunction

  // Bits as they appear on the wire, index 0 first: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic p;
    p = ((ones(d) % 2) == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  function automatic logic rx_good(input logic [7:0] d, input logic par, input logic stop);
    return stop && (((ones(d) + int'(par)) % 2) == 1);
  endfunction

  task automatic wait_clk_oe(input logic lvl, input string tag);
    int n = 0;
    while (ps2_clk_oe !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, ps2_clk_oe, lvl);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic count_clk_activity(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ps2_clk_oe !== 1'b0) hits++;
    end
  endtask

  // Records the data line at each device clock fall and every phase length.
  task automatic tx_capture(output logic [10:0] bits, output int bad_phase, output logic timed_out);
    int n;
    bits = '0;
    bad_phase = 0;
    timed_out = 1'b0;
    for (int i = 0; i < 11; i++) begin
      n = 0;
      while (ps2_clk_oe !== 1'b1 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 3000) begin
        timed_out = 1'b1;
        return;
      end
      bits[i] = ps2_dat_in;
      n = 0;
      while (ps2_clk_oe === 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n != HALF) bad_phase++;
      if (i < 10) begin
        n = 0;
        while (ps2_clk_oe === 1'b0 && n < 100) begin
          @(negedge clk);
          n++;
        end
        if (n != HALF) bad_phase++;
      end
    end
  endtask

  task automatic check_frame(input logic [7:0] d, input string tag);
    logic [10:0] bits;
    int          bad;
    logic        to;
    tx_capture(bits, bad, to);
    check({tag, "_timeout"}, to, 1'b0);
    check({tag, "_bits"}, bits, model_frame(d));
    check({tag, "_phase_len"}, bad, 0);
    wait_idle({tag, "_idle"});
    check({tag, "_ready_after"}, tx_ready, 1'b1);
  endtask

  task automatic tx_send(input logic [7:0] d, input string tag);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check({tag, "_ready_low"}, tx_ready, 1'b0);
    check_frame(d, tag);
  endtask

  task automatic host_rts_begin();
    @(negedge clk);
    host_clk = 1'b0;
    repeat (100) @(negedge clk);
  endtask

  task automatic host_rts_finish();
    host_dat = 1'b0;
    repeat (10) @(negedge clk);
    host_clk = 1'b1;
  endtask

  // Host presents each bit while the device holds the clock low.
  task automatic host_bits(input logic [7:0] d, input logic par, input logic stop, output logic ack);
    logic [9:0] b;
    b = {stop, par, d};
    for (int i = 0; i < 10; i++) begin
      wait_clk_oe(1'b1, "rx_clk_fall");
      repeat (5) @(negedge clk);
      host_dat = b[i];
      wait_clk_oe(1'b0, "rx_clk_rise");
    end
    wait_clk_oe(1'b1, "ack_clk_fall");
    host_dat = 1'b1;
    repeat (3) @(negedge clk);
    ack = (ps2_dat_oe === 1'b1);
    repeat (30) @(negedge clk);
    ack = ack && (ps2_dat_oe === 1'b1) && (ps2_clk_oe === 1'b1);
    wait_clk_oe(1'b0, "ack_clk_rise");
    ack = ack && (ps2_dat_oe === 1'b0);
  endtask

  task automatic finish_rx(input logic [7:0] d, input logic good, input int v0, input int e0,
                           input string tag);
    repeat (60) @(negedge clk);
    check({tag, "_valid_pulses"}, nvalid - v0, good ? 1 : 0);
    check({tag, "_error_pulses"}, nerr - e0, good ? 0 : 1);
    if (good) exp_rx = d;
    check({tag, "_rx_data"}, rx_data, exp_rx);
    wait_idle({tag, "_idle"});
  endtask

  task automatic do_rx(input logic [7:0] d, input logic par, input logic stop, input string tag);
    int   v0, e0;
    logic ack;
    v0 = nvalid;
    e0 = nerr;
    host_rts_begin();
    host_rts_finish();
    host_bits(d, par, stop, ack);
    check({tag, "_ack"}, ack, 1'b1);
    finish_rx(d, rx_good(d, par, stop), v0, e0, tag);
  endtask

  initial begin
    int          hits;
    int          v0, e0;
    logic        ack;
    logic [7:0]  rd;
    logic        rp, rs;

    reset    = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    host_clk = 1'b1;
    host_dat = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_dat_oe", ps2_dat_oe, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_error", rx_error, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_busy", busy, 1'b0);

    // Send 0x1C; a second byte offered while tx_ready is low must be dropped.
    tx_data  = 8'h1C;
    tx_valid = 1'b1;
    @(negedge clk);
    check("send_ready_low", tx_ready, 1'b0);
    tx_data = 8'h77;
    @(negedge clk);
    tx_valid = 1'b0;
    check_frame(8'h1C, "send_1c");
    count_clk_activity(200, hits);
    check("ignored_byte_not_sent", hits, 0);

    do_rx(8'hFF, 1'b1, 1'b1, "rx_ff");
    do_rx(8'h00, 1'b0, 1'b1, "rx_bad_parity");

    // Host inhibits during the 4th clock-high phase; the byte must be retried.
    @(negedge clk);
    tx_data  = 8'h1C;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      wait_clk_oe(1'b1, "inh_fall");
      wait_clk_oe(1'b0, "inh_rise");
    end
    repeat (10) @(negedge clk);
    host_clk = 1'b0;
    repeat (60) @(negedge clk);
    check("inh_clk_oe", ps2_clk_oe, 1'b0);
    check("inh_dat_oe", ps2_dat_oe, 1'b0);
    check("inh_tx_ready", tx_ready, 1'b0);
    check("inh_busy", busy, 1'b1);
    host_clk = 1'b1;
    check_frame(8'h1C, "inh_retry");

    // Pending byte and request-to-send together: host frame goes first.
    v0 = nvalid;
    e0 = nerr;
    host_rts_begin();
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("prio_ready_low", tx_ready, 1'b0);
    repeat (5) @(negedge clk);
    check("prio_no_tx_clock", ps2_clk_oe, 1'b0);
    host_rts_finish();
    host_bits(8'h3C, 1'b1, 1'b1, ack);
    check("prio_ack", ack, 1'b1);
    repeat (60) @(negedge clk);
    check("prio_valid_pulses", nvalid - v0, 1);
    check("prio_error_pulses", nerr - e0, 0);
    exp_rx = 8'h3C;
    check("prio_rx_data", rx_data, exp_rx);
    check_frame(8'hA5, "prio_tx");

    for (int k = 0; k < 3; k++) begin
      tx_send(8'($urandom_range(0, 255)), "rand_tx");
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      do_rx(rd, rp, rs, "rand_rx");
    end

    // Reset in the middle of a host frame, with a byte also held.
    host_rts_begin();
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    host_rts_finish();
    wait_clk_oe(1'b1, "rstmid_rx_low");
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rstmid_clk_oe", ps2_clk_oe, 1'b0);
    check("rstmid_dat_oe", ps2_dat_oe, 1'b0);
    check("rstmid_tx_ready", tx_ready, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_rx_data", rx_data, 8'h00);
    check("rstmid_rx_valid", rx_valid, 1'b0);
    check("rstmid_rx_error", rx_error, 1'b0);
    exp_rx = 8'h00;
    @(negedge clk);
    reset    = 1'b0;
    host_clk = 1'b1;
    host_dat = 1'b1;
    count_clk_activity(300, hits);
    check("rstmid_byte_discarded", hits, 0);
    check("rstmid_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
